seg7_hex_encoder: RTL

- Inverse of the board's 4-bit to 7-segment decoder. Accepts a stream of active-low 7-segment patterns over a valid/ready handshake and encodes each pattern back to its hex nibble.
- Packs NUM_DIGITS nibbles into one word and presents the word over a second valid/ready handshake.
- Used in lab loopback/self-check: decoder outputs (or captured HEX patterns) feed this block, and the recovered word is compared against the switch value.

---
 rtl/seg7_hex_encoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seg7_hex_encoder.sv
// seg7_hex_encoder
// Turns a stream of active-low 7-segment patterns back into hex nibbles and
// packs NUM_DIGITS of them into one word. The first accepted digit lands in
// the most significant nibble. Both sides use valid/ready handshakes.
// Unrecognised patterns encode to 0 and raise word_err for that word.
module seg7_hex_encoder #(
    parameter int NUM_DIGITS = 4  // legal range 1..8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    output logic                    seg_ready,
    input  logic                    flush,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    word_err,
    output logic [3:0]              digit_count
);

    localparam int WW = 4 * NUM_DIGITS;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]    state;
    logic          live;        // low in reset, high from the first edge after release
    logic [WW-1:0] shift_q;
    logic [WW-1:0] shifted;
    logic          err_acc;
    logic [3:0]    nibble;
    logic          invalid;
    logic          seg_hs;
    logic          last_digit;

    // Pattern-to-nibble lookup; anything outside the table is flagged invalid.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        nibble  = 4'h0;
        invalid = 1'b0;
        case (seg_in)
            7'h40: nibble = 4'h0;
            7'h79: nibble = 4'h1;
            7'h24: nibble = 4'h2;
            7'h30: nibble = 4'h3;
            7'h19: nibble = 4'h4;
            7'h12: nibble = 4'h5;
            7'h02: nibble = 4'h6;
            7'h78: nibble = 4'h7;
            7'h00: nibble = 4'h8;
            7'h10: nibble = 4'h9;
            7'h08: nibble = 4'hA;
            7'h03: nibble = 4'hB;
            7'h46: nibble = 4'hC;
            7'h21: nibble = 4'hD;
            7'h06: nibble = 4'hE;
            7'h0E: nibble = 4'hF;
            default: invalid = 1'b1;
        endcase
    end

    // ready depends only on registered state, so seg_valid never reaches an output combinationally
    assign seg_ready  = live & (state == COLLECT);
    assign seg_hs     = seg_valid & seg_ready;
    assign last_digit = (digit_count == 4'(NUM_DIGITS - 1));
    assign shifted    = (shift_q << 4) | WW'(nibble);

    // Holds seg_ready low until the first clock edge after reset release.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) live <= 1'b0;
        else         live <= 1'b1;
    end

    // Collect digits, then present the packed word until the consumer takes it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= COLLECT;
            shift_q     <= '0;
            err_acc     <= 1'b0;
            digit_count <= 4'd0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            word_err    <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (flush) begin
                        // flush beats a same-cycle handshake; that digit is dropped
                        shift_q     <= '0;
                        digit_count <= 4'd0;
                        err_acc     <= 1'b0;
                    end else if (seg_hs) begin
                        shift_q     <= shifted;
                        digit_count <= digit_count + 4'd1;
                        err_acc     <= err_acc | invalid;
                        if (last_digit) begin
                            word_out   <= shifted;
                            word_err   <= err_acc | invalid;
                            word_valid <= 1'b1;
                            state      <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    // flush is ignored here: a presented word is never discarded
                    if (word_ready) begin
                        word_valid  <= 1'b0;
                        word_err    <= 1'b0;
                        digit_count <= 4'd0;
                        err_acc     <= 1'b0;
                        state       <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
